// File: rtl/risc_net_pkg.sv
// risc_net_pkg: shared definitions for the risc_net_core processor.
//   - opcode_e : 4-bit opcode encodings (B..E are illegal and behave as HALT)
//   - instr_t  : 32-bit instruction layout op[31:28] rd[27:24] rs1[23:20]
//                rs2[19:16] imm[15:0]
//   - state_e  : control FSM states
//   - is_halt_op(): true for HALT and every illegal opcode
package risc_net_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LDI  = 4'h7,
    OP_BEQ  = 4'h8,
    OP_BNE  = 4'h9,
    OP_JMP  = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_e;

  // Opcodes B..E are undefined; they stop the core exactly like HALT (F).
  function automatic logic is_halt_op(input logic [3:0] op);
    return op >= 4'hB;
  endfunction

endpackage

// File: rtl/risc_regfile.sv
// risc_regfile: NUM_REGS x DATA_W register file.
//   clk, reset         : clock, synchronous active-high reset (clears all)
//   rs1_idx/rs1_data   : combinational read port 1
//   rs2_idx/rs2_data   : combinational read port 2
//   wr_en/wr_idx/wr_data : synchronous write port (writes to r0 dropped)
//   dbg_idx/dbg_data   : combinational debug read, 0 when dbg_idx >= NUM_REGS
module risc_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rs1_idx,
  output logic [DATA_W-1:0] rs1_data,
  input  logic [IDX_W-1:0]  rs2_idx,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_idx != '0)) begin
      regs_d[wr_idx] = wr_data;
    end
  end

  // NOTE: the array is reset element by element because the core must come
  // out of reset with every register reading zero; a storage array without
  // that requirement would be left unreset so it can map to RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rs1_data = (rs1_idx == '0) ? '0 : regs_q[rs1_idx];
  assign rs2_data = (rs2_idx == '0) ? '0 : regs_q[rs2_idx];

  assign dbg_data = ({1'b0, dbg_idx} < NUM_REGS_W) ? regs_q[dbg_idx[IDX_W-1:0]] : '0;

endmodule

// File: rtl/risc_net_core.sv
// risc_net_core: multicycle processor core (IDLE -> FETCH -> EXEC loop).
//   clk, reset        : clock, synchronous active-high reset
//   run               : level; leaves IDLE while high, returns to IDLE after
//                       the current instruction when low
//   imem_req/imem_addr: registered fetch request, held until imem_valid
//   imem_valid/rdata  : instruction return (ignored outside FETCH)
//   pc                : current program counter (word address)
//   retire            : one-cycle pulse per executed instruction
//   halted            : high once a HALT/illegal instruction has executed
//   dbg_reg_id/data   : combinational debug read of the register file
module risc_net_core
  import risc_net_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted,
  input  logic [3:0]        dbg_reg_id,
  output logic [DATA_W-1:0] dbg_reg_data
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  instr_t            ir_q, ir_d;
  logic              req_q, req_d;
  logic              retire_q, retire_d;

  logic [DATA_W-1:0] rs1_data, rs2_data, imm_ext, alu_res;
  logic              alu_we, accept, branch_eq;
  logic [ADDR_W-1:0] pc_inc, pc_exec, br_target;

  risc_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .IDX_W   (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rs1_idx (ir_q.rs1[IDX_W-1:0]),
    .rs1_data(rs1_data),
    .rs2_idx (ir_q.rs2[IDX_W-1:0]),
    .rs2_data(rs2_data),
    .wr_en   ((state_q == ST_EXEC) && alu_we),
    .wr_idx  (ir_q.rd[IDX_W-1:0]),
    .wr_data (alu_res),
    .dbg_idx (dbg_reg_id),
    .dbg_data(dbg_reg_data)
  );

  // Immediate is sign-extended for wide datapaths, truncated for narrow ones.
  if (DATA_W > 16) begin : g_imm_sext
    assign imm_ext = {{(DATA_W-16){ir_q.imm[15]}}, ir_q.imm};
  end else begin : g_imm_trunc
    assign imm_ext = ir_q.imm[DATA_W-1:0];
  end

  assign br_target = ir_q.imm[ADDR_W-1:0];
  assign pc_inc    = pc_q + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
  assign branch_eq = (rs1_data == rs2_data);
  // A response only counts once our registered request is actually out.
  assign accept    = (state_q == ST_FETCH) && req_q && imem_valid;

  always_comb begin
    alu_res = '0;
    alu_we  = 1'b0;
    case (ir_q.op)
      OP_ADD:  begin alu_res = rs1_data + rs2_data; alu_we = 1'b1; end
      OP_SUB:  begin alu_res = rs1_data - rs2_data; alu_we = 1'b1; end
      OP_AND:  begin alu_res = rs1_data & rs2_data; alu_we = 1'b1; end
      OP_OR:   begin alu_res = rs1_data | rs2_data; alu_we = 1'b1; end
      OP_XOR:  begin alu_res = rs1_data ^ rs2_data; alu_we = 1'b1; end
      OP_ADDI: begin alu_res = rs1_data + imm_ext;  alu_we = 1'b1; end
      OP_LDI:  begin alu_res = imm_ext;             alu_we = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    pc_exec = pc_inc;
    case (ir_q.op)
      OP_BEQ:  if (branch_eq)  pc_exec = br_target;
      OP_BNE:  if (!branch_eq) pc_exec = br_target;
      OP_JMP:  pc_exec = br_target;
      default: if (is_halt_op(ir_q.op)) pc_exec = pc_q;  // HALT keeps its own pc
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    req_d    = 1'b0;
    retire_d = 1'b0;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (accept) begin
          ir_d    = instr_t'(imem_rdata);
          state_d = ST_EXEC;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_EXEC: begin
        pc_d     = pc_exec;
        retire_d = 1'b1;
        if (is_halt_op(ir_q.op)) state_d = ST_HALT;
        else if (!run)           state_d = ST_IDLE;
        else                     state_d = ST_FETCH;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= ADDR_W'(RESET_PC);
      ir_q     <= '0;
      req_q    <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      req_q    <= req_d;
      retire_q <= retire_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign retire    = retire_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: doc/risc_net_core.md
# risc_net_core

Parametrised multicycle processor core, successor to the fixed-width fetch/register arrangement in the current top level. It fetches 32-bit instructions over a request/valid memory port, decodes them, reads and writes a parametrised register file, executes ALU and branch operations, and reports retirement and halt status. It sits between the instruction memory and the system top, replacing the free-running fetch glue.

## Interface
Parameters:
- DATA_W, 16, register and ALU width (8..32)
- ADDR_W, 16, instruction address / PC width (≤16)
- NUM_REGS, 16, register count (2..16, power of two)
- RESET_PC, 0, PC value after reset

Ports:
- Clock and reset: one clock; reset is synchronous and active-high (ports `clk`, `reset`).
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- run  in  1  level; core leaves IDLE when high
- imem_req  out  1  fetch request, held until imem_valid
- imem_addr  out  ADDR_W  fetch address (= pc while imem_req)
- imem_valid  in  1  imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- pc  out  ADDR_W  current PC
- retire  out  1  one-cycle pulse per executed instruction
- halted  out  1  high in HALT state
- dbg_reg_id  in  4  debug register-file read select
- dbg_reg_data  out  DATA_W  combinational read of register dbg_reg_id (0 if index ≥ NUM_REGS)

## Operation
- Instruction format: op[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm[15:0]; register indices use low log2(NUM_REGS) bits.
- Opcodes: 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR (rd = rs1 op rs2); 6 ADDI (rd = rs1 + sext(imm)); 7 LDI (rd = sext(imm)); 8 BEQ (if rs1 == rs2, pc = imm[ADDR_W-1:0]); 9 BNE; A JMP (pc = imm); F HALT; B–E illegal, treated as HALT.
- Register 0 reads zero; writes to it are discarded.
- Arithmetic modulo 2^DATA_W; imm sign-extended or truncated to DATA_W.
- PC increments by 1 (word addressed), wraps from 2^ADDR_W−1 to 0.
- FSM states: IDLE → FETCH when run=1. FETCH: imem_req=1, imem_addr=pc; on imem_valid latch IR → EXEC. EXEC: compute, write rd, update pc, pulse retire; → HALT if HALT/illegal, IDLE if run=0, else FETCH. HALT: stays until reset.
- imem_valid seen while not in FETCH is ignored.
- run dropping mid-fetch does not abort; the instruction completes, then IDLE.

## Timing
- Reset values: state IDLE, pc=RESET_PC, registers 0, imem_req=0, retire=0, halted=0, IR=0.
- Reset asserted mid-instruction wins on the next edge; an in-flight fetch is abandoned and the memory must tolerate the dropped request.
- imem_req rises the cycle after entering FETCH (registered), imem_addr stable while imem_req=1.
- Zero-wait memory (imem_valid the cycle after imem_req rises): 3 cycles per instruction (FETCH, FETCH-accept, EXEC). Each wait cycle adds one.
- Register write and pc update take effect at the EXEC clock edge; retire high the cycle after.
- dbg_reg_data reflects a write the cycle after it is committed.
- halted rises the cycle after the HALT instruction's EXEC edge; retire pulses for HALT too.

## Structure
- Shared package risc_net_pkg: opcode constants, instruction field positions, FSM state enum.
- Sub-module risc_regfile (parametrised NUM_REGS × DATA_W, two combinational read ports plus debug port, one synchronous write port, r0 hardwired zero).
- ALU inline in the core.

## Test plan
- Reset then run=1, program LDI r1,5; LDI r2,7; ADD r3,r1,r2; HALT → r3=12 via debug port, halted=1, 4 retire pulses, pc=3.
- SUB r1,r0,r2 with r2=1, DATA_W=16 → r1=0xFFFF; ADDI r1,r1,1 → 0.
- BEQ taken (r1==r2) to 0x0010 and BNE not taken → pc sequence 0x0010 then next+1; JMP at ADDR_W=8 with imm=0x1FF → pc=0xFF, then wrap to 0x00.
- Memory returns imem_valid after 3 wait cycles → imem_addr/imem_req held stable throughout; instruction takes 6 cycles.
- Write to r0 (LDI r0,9) → debug read of r0 returns 0; opcode 0xC → halted=1, no register change.
- Reset asserted while waiting for imem_valid → next cycle IDLE, pc=RESET_PC, all registers 0, late imem_valid ignored.
